// File: rtl/mul_result_stage.sv
// Multiplier result stage: selects the MUL low or MULH* high half, tags it with rd, and queues it for writeback.
// Latency 1 cycle from in_fire to out_valid when empty; sustains 1 result/cycle while out_ready=1.
// Backpressure: 2-entry skid (main + skid); in_ready decodes registered state only. Optional macro: MUL_RESULT_X0_DROP_EN.
module mul_result_stage #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mul_opcode,
    input  logic [2*XLEN-1:0]   result_multiply,
    input  logic [RD_W-1:0]     rd_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic [RD_W-1:0]     out_rd,
    output logic                busy,
    output logic [CNT_W-1:0]    mul_count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  main_data_q, main_data_d;
    logic [RD_W-1:0]  main_rd_q, main_rd_d;
    logic [XLEN-1:0]  skid_data_q, skid_data_d;
    logic [RD_W-1:0]  skid_rd_q, skid_rd_d;
    logic [CNT_W-1:0] mul_count_q, mul_count_d;

    logic [XLEN-1:0]  sel_data;
    logic             in_fire;
    logic             out_fire;
    logic             enq;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Half selection ahead of storage, so only XLEN bits are held per entry
    always_comb begin
        sel_data = result_multiply[XLEN-1:0];
        if (mul_opcode != 2'b00) begin
            sel_data = result_multiply[2*XLEN-1:XLEN];
        end
    end

    // Handshakes; an x0-targeted result may be accepted but not enqueued
    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
`ifdef MUL_RESULT_X0_DROP_EN
        enq      = in_fire & (rd_addr != '0);
`else
        enq      = in_fire;
`endif
    end

    // Next-state logic and storage load strobes; flush overrides everything
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (enq) begin
                        load_main_in = 1'b1;
                        state_d      = S_ONE;
                    end
                end
                S_ONE: begin
                    if (enq && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (enq) begin
                        load_skid = 1'b1;
                        state_d   = S_FULL;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_d        = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Outputs decoded purely from registered state (no out_ready -> in_ready path)
    always_comb begin
        out_valid = (state_q == S_ONE) || (state_q == S_FULL);
        in_ready  = (state_q != S_FULL);
        busy      = (state_q != S_EMPTY);
        out_data  = main_data_q;
        out_rd    = main_rd_q;
        mul_count = mul_count_q;
    end

    // Storage and counter next values; registers move only on their load events
    always_comb begin
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        if (load_main_in) begin
            main_data_d = sel_data;
            main_rd_d   = rd_addr;
        end else if (load_main_skid) begin
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
        end
        if (load_skid) begin
            skid_data_d = sel_data;
            skid_rd_d   = rd_addr;
        end
        mul_count_d = mul_count_q + {{(CNT_W-1){1'b0}}, out_fire};
    end

    // State, storage and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            mul_count_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            mul_count_q <= mul_count_d;
        end
    end

endmodule

// File: tb/tb_mul_result_stage.sv
// Bench for mul_result_stage: FIFO model of the result queue checked every cycle, plus directed literal checks.
// Uses a 4-bit counter so mul_count wrap is exercised by the random phase.
// Optional macro MUL_RESULT_X0_DROP_EN switches the expectations for rd=0 results.
module tb_mul_result_stage;

    localparam int XLEN  = 32;
    localparam int RD_W  = 5;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mul_opcode;
    logic [2*XLEN-1:0]  result_multiply;
    logic [RD_W-1:0]    rd_addr;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_data;
    logic [RD_W-1:0]    out_rd;
    logic               busy;
    logic [CNT_W-1:0]   mul_count;

    always #5 clk = ~clk;

    mul_result_stage #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .mul_opcode      (mul_opcode),
        .result_multiply (result_multiply),
        .rd_addr         (rd_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_rd          (out_rd),
        .busy            (busy),
        .mul_count       (mul_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [XLEN-1:0] d;
        logic [RD_W-1:0] rd;
    } ent_t;

    ent_t mq[$];
    int   mcount = 0;

    function automatic logic [XLEN-1:0] pick(input logic [1:0] op, input logic [2*XLEN-1:0] p);
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: compare the DUT to the queue, then advance the queue to what the next edge must produce
    always @(negedge clk) begin : compare
        bit ofire, ifire, keep;
        chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("m_in_ready",  64'(in_ready),  64'(mq.size() < 2));
        chk("m_busy",      64'(busy),      64'(mq.size() > 0));
        chk("m_mul_count", 64'(mul_count), 64'(mcount));
        if (mq.size() > 0) begin
            chk("m_out_data", 64'(out_data), 64'(mq[0].d));
            chk("m_out_rd",   64'(out_rd),   64'(mq[0].rd));
        end
        if (rst) begin
            mq.delete();
            mcount = 0;
        end else begin
            ofire = (mq.size() > 0) && out_ready;
            ifire = in_valid && (mq.size() < 2);
`ifdef MUL_RESULT_X0_DROP_EN
            keep = (rd_addr != '0);
`else
            keep = 1'b1;
`endif
            if (ofire) begin
                void'(mq.pop_front());
                mcount = (mcount + 1) % (1 << CNT_W);
            end
            if (flush) begin
                mq.delete();
            end else if (ifire && keep) begin
                mq.push_back('{d: pick(mul_opcode, result_multiply), rd: rd_addr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] op, input logic [63:0] p, input logic [4:0] rd);
        in_valid        = v;
        mul_opcode      = op;
        result_multiply = p;
        rd_addr         = rd;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drv(1'b1, 2'b00, 64'h1234_5678_9ABC_DEF0, 5'd9);
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_rd",    64'(out_rd),    64'd0);
        chk("rst_mul_count", 64'(mul_count), 64'd0);
        rst = 1'b0;
        drv(1'b0, 2'b00, 64'd0, 5'd0);
        tick();

        // MUL low half
        out_ready = 1'b1;
        drv(1'b1, 2'b00, 64'h0000_0001_FFFF_FFFE, 5'd5);
        tick();
        drv(1'b0, 2'b00, 64'd0, 5'd0);
        chk("mul_lo_valid", 64'(out_valid), 64'd1);
        chk("mul_lo_data",  64'(out_data),  64'hFFFF_FFFE);
        chk("mul_lo_rd",    64'(out_rd),    64'd5);
        tick();
        chk("mul_lo_count", 64'(mul_count), 64'd1);
        chk("mul_lo_drain", 64'(out_valid), 64'd0);

        // High half, back to back
        drv(1'b1, 2'b11, 64'hFFFF_FFFE_0000_0001, 5'd7);
        tick();
        chk("mulhu_data", 64'(out_data), 64'hFFFF_FFFE);
        chk("mulhu_rd",   64'(out_rd),   64'd7);
        drv(1'b1, 2'b01, 64'h8000_0000_0000_0000, 5'd8);
        tick();
        drv(1'b0, 2'b00, 64'd0, 5'd0);
        chk("mulh_data", 64'(out_data), 64'h8000_0000);
        chk("mulh_rd",   64'(out_rd),   64'd8);
        tick();
        chk("hi_count", 64'(mul_count), 64'd3);

        // Backpressure: A, B fill the stage, C waits upstream
        out_ready = 1'b0;
        drv(1'b1, 2'b00, 64'h11, 5'd1);
        tick();
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        drv(1'b1, 2'b00, 64'h22, 5'd2);
        tick();
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_full_data",  64'(out_data), 64'h11);
        drv(1'b1, 2'b00, 64'h33, 5'd3);
        tick();
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_data",  64'(out_data), 64'h11);
        chk("bp_hold_rd",    64'(out_rd),   64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_data", 64'(out_data), 64'h22);
        chk("bp_b_rd",   64'(out_rd),   64'd2);
        tick();
        drv(1'b0, 2'b00, 64'd0, 5'd0);
        chk("bp_c_data", 64'(out_data), 64'h33);
        chk("bp_c_rd",   64'(out_rd),   64'd3);
        tick();
        chk("bp_count", 64'(mul_count), 64'd6);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a new input and no output handshake
        out_ready = 1'b0;
        drv(1'b1, 2'b00, 64'h44, 5'd4);
        tick();
        drv(1'b1, 2'b00, 64'h55, 5'd5);
        tick();
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drv(1'b1, 2'b00, 64'h66, 5'd6);
        tick();
        flush = 1'b0;
        drv(1'b0, 2'b00, 64'd0, 5'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready),  64'd1);
        chk("fl_busy",  64'(busy),      64'd0);
        chk("fl_count", 64'(mul_count), 64'd6);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_stale", 64'(out_valid), 64'd0);

        // Destination x0
        drv(1'b1, 2'b00, 64'hDEAD_0000_0000_0042, 5'd0);
        tick();
        drv(1'b0, 2'b00, 64'd0, 5'd0);
`ifdef MUL_RESULT_X0_DROP_EN
        chk("x0_valid", 64'(out_valid), 64'd0);
        tick();
        chk("x0_count", 64'(mul_count), 64'd6);
`else
        chk("x0_valid", 64'(out_valid), 64'd1);
        chk("x0_data",  64'(out_data),  64'h42);
        chk("x0_rd",    64'(out_rd),    64'd0);
        tick();
        chk("x0_count", 64'(mul_count), 64'd7);
`endif

        // Random traffic with occasional flushes; the model checks every cycle
        for (int i = 0; i < 300; i++) begin
            drv(1'($urandom_range(0, 1)), 2'($urandom), {$urandom, $urandom}, 5'($urandom_range(0, 4)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0;

        // Reset in the middle of a backed-up transaction
        out_ready = 1'b0;
        drv(1'b1, 2'b00, 64'h77, 5'd1);
        tick();
        drv(1'b1, 2'b00, 64'h88, 5'd2);
        tick();
        rst = 1'b1;
        drv(1'b1, 2'b00, 64'h99, 5'd3);
        tick();
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(in_ready),  64'd1);
        chk("mrst_data",  64'(out_data),  64'd0);
        chk("mrst_rd",    64'(out_rd),    64'd0);
        chk("mrst_count", 64'(mul_count), 64'd0);
        rst = 1'b0;
        drv(1'b0, 2'b00, 64'd0, 5'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_result_stage.md
Name: mul_result_stage

Overview:
Registered result stage directly downstream of the combinational 32-bit multiplier in the M-extension execute path. It selects the architectural 32-bit result from the 64-bit product using mul_opcode: MUL takes the low half, MULH/MULHSU/MULHU take the high half. It tags the result with the destination register. It hands the result to writeback over a valid/ready interface, with a 2-entry skid buffer so writeback stalls never create a combinational ready path back into execute.

Parameters:
XLEN, 32, architectural result width; the product input is 2*XLEN.
RD_W, 5, destination register index width.
CNT_W, 32, width of the completed-operation counter.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  pipeline flush (branch mispredict or trap); discards all held results.
in_valid  input  1  product, opcode and rd are valid this cycle.
in_ready  output  1  stage can accept a transaction this cycle.
mul_opcode  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
result_multiply  input  64  full product from the multiplier.
rd_addr  input  RD_W  destination register index.
out_valid  output  1  result available to writeback.
out_ready  input  1  writeback accepts the result.
out_data  output  XLEN  selected 32-bit result.
out_rd  output  RD_W  destination tag of out_data.
busy  output  1  at least one result held (state != EMPTY).
mul_count  output  CNT_W  number of completed output handshakes; wraps at 2^CNT_W.

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Half selection happens before storage. opcode 00 selects result_multiply[31:0]; 01, 10 and 11 select result_multiply[63:32]. Only 32 bits plus rd are stored per entry.
- Storage: a main entry drives out_data/out_rd; a skid entry is used only under backpressure.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1. On in_fire, load main and go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - in_fire & out_fire: reload main, stay in ONE.
    - in_fire & !out_fire: load skid, go to FULL.
    - !in_fire & out_fire: go to EMPTY.
    - Neither: hold.
  - FULL: out_valid=1, in_ready=0. On out_fire, main<=skid and go to ONE; otherwise hold.
- in_ready is decoded from registered state only; there is no combinational path from out_ready to in_ready.
- Latency: 1 cycle from in_fire to out_valid when the stage was EMPTY. Throughput is 1 per cycle when out_ready=1.
- Ordering is strictly FIFO; no result is lost or duplicated.
- While out_valid=1 and out_ready=0, out_data and out_rd are held stable.
- Flush:
  - Next state is EMPTY; main and skid are invalidated.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle completes normally and increments mul_count.
  - Flush has priority over every other transition.
- mul_count increments by 1 on each out_fire and wraps from all-ones to 0. It is unaffected by flush.
- Reset (rst=1 at an edge, including mid-transaction):
  - state=EMPTY, out_valid=0, in_ready=1, busy=0.
  - out_data=0, out_rd=0, skid contents=0, mul_count=0.
  - Inputs are ignored during reset.
- Storage registers update only on their load events, never on idle cycles.

Optional Feature:
MUL_RESULT_X0_DROP_EN.
- Defined: a transaction with rd_addr==0 completes the input handshake normally but is not enqueued. State is unchanged by that transaction, and it never appears at the output or in mul_count.
- Undefined: rd_addr==0 results flow through like any other; writeback ignores them.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, busy=0, out_data=0, out_rd=0, mul_count=0.
- MUL low half: opcode 00, product 64'h0000_0001_FFFF_FFFE, rd 5, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF_FFFE, out_rd=5; mul_count=1 after handshake.
- High half: opcode 11 with product 64'hFFFF_FFFE_0000_0001, rd 7, then opcode 01 with product 64'h8000_0000_0000_0000, rd 8, back-to-back -> out_data 32'hFFFF_FFFE (rd 7), then 32'h8000_0000 (rd 8), on consecutive cycles.
- Backpressure: out_ready=0, issue A (rd 1), B (rd 2), C (rd 3) every cycle -> in_ready=0 after B, C held upstream and out_data stable at A. Then out_ready=1 -> A, B, C delivered in order on 3 consecutive cycles; mul_count=3.
- Flush in FULL with in_valid=1 and out_ready=0 -> next cycle out_valid=0, in_ready=1, busy=0, mul_count unchanged, no stale result ever emitted.
- rd_addr=0, opcode 00 -> with MUL_RESULT_X0_DROP_EN: out_valid stays 0 and mul_count stays 0. Without it: delivered with out_rd=0.
